// File: rtl/stopwatch_tenths_counter.sv
// Stopwatch core: conditions three raw buttons, runs the IDLE/RUN/PAUSE machine
// and the 0.1 s timebase, and registers a 0..9999 count for the display driver.

module stopwatch_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_q;
    logic [CW-1:0] stable_cnt;

    // Reset assumes the button is held, so a press that spans reset must be
    // released and pressed again before it counts as an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= 2'b11;
            level      <= 1'b1;
            level_q    <= 1'b1;
            stable_cnt <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            if (sync[1] == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level      <= sync[1];
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_q;
endmodule

module stopwatch_tenths_counter #(
    parameter int CLK_FREQ_HZ     = 100000000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [13:0] displayed_number,
    output logic        running,
    output logic        lap_hold,
    output logic        wrapped
);
    localparam int NUM_BTN = 3;
    localparam int DIV     = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t               state;
    logic [PW-1:0]        presc;
    logic [13:0]          count;
    logic [NUM_BTN-1:0]   btn_raw;
    logic [NUM_BTN-1:0]   btn_ev;
    logic                 ss_ev;
    logic                 clr_ev;
    logic                 lap_ev;
    logic                 tick;

    assign btn_raw = {btn_lap, btn_clear, btn_start_stop};

    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_btn
            stopwatch_btn_cond #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .clk   (clk),
                .rst   (rst),
                .btn   (btn_raw[i]),
                .press (btn_ev[i])
            );
        end
    endgenerate

    assign ss_ev  = btn_ev[0];
    assign clr_ev = btn_ev[1];
    assign lap_ev = btn_ev[2];
    assign tick   = (state == RUN) && (presc == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr_ev) begin
            state            <= IDLE;
            presc            <= '0;
            count            <= '0;
            displayed_number <= '0;
            running          <= 1'b0;
            lap_hold         <= 1'b0;
            wrapped          <= 1'b0;
        end else begin
            // Entering a hold also loads here, latching the count of the lap cycle.
            if (!lap_hold)
                displayed_number <= count;

            if (state == RUN) begin
                if (tick) begin
                    presc <= '0;
                    if (count == 14'd9999) begin
                        count   <= '0;
                        wrapped <= 1'b1;
                    end else begin
                        count <= count + 14'd1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            if (ss_ev) begin
                case (state)
                    IDLE:    begin state <= RUN;   running <= 1'b1; end
                    RUN:     begin state <= PAUSE; running <= 1'b0; end
                    PAUSE:   begin state <= RUN;   running <= 1'b1; end
                    default: begin state <= IDLE;  running <= 1'b0; end
                endcase
            end else if (lap_ev) begin
                if (state == RUN)
                    lap_hold <= ~lap_hold;
                else if (state == PAUSE)
                    lap_hold <= 1'b0;
            end
        end
    end
endmodule
